// File: rtl/scanline_ctrl_pkg.sv
// Shared definitions for the scanline control slice.
//   fade_state_t : encoding of the scanline fade sequencer states
//   sl_cfg_t     : one complete scanline configuration set (pending / active)
//   STEP_MIN/MAX : legal range of the Q1.8 vertical step
//   clamp_step   : forces a requested step into the legal range
package scanline_ctrl_pkg;

  typedef enum logic [1:0] {
    FADE_OFF = 2'd0,
    FADE_IN  = 2'd1,
    FADE_ON  = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  localparam logic [8:0] STEP_MIN = 9'h010;
  localparam logic [8:0] STEP_MAX = 9'h100;

  typedef struct packed {
    logic       en;
    logic       thick;
    logic [1:0] profile;
    logic [7:0] strength;
    logic [4:0] bloom;
    logic [8:0] step;
  } sl_cfg_t;

  function automatic logic [8:0] clamp_step(input logic [8:0] step);
    if (step > STEP_MAX) begin
      return STEP_MAX;
    end else if (step < STEP_MIN) begin
      return STEP_MIN;
    end
    return step;
  endfunction

endpackage

// File: rtl/scanline_fade_fsm.sv
// Frame-rate fade sequencer for scanline strength.
// Advances one step per frame start: fades the effective strength from 0 up
// to the target when scanlines are enabled and back down to 0 when disabled.
// Ports:
//   VCLK_i, nVRST_i : video clock, asynchronous active-low reset
//   frame_start     : one-cycle frame boundary pulse
//   sl_en           : scanlines requested (value applied at this frame start)
//   target          : requested strength (value applied at this frame start)
//   fade_en         : scanlines visible (any state but OFF)
//   cur             : current effective strength
module scanline_fade_fsm
  import scanline_ctrl_pkg::*;
#(
  parameter logic [7:0] FADE_STEP = 8'h10
) (
  input  logic       VCLK_i,
  input  logic       nVRST_i,
  input  logic       frame_start,
  input  logic       sl_en,
  input  logic [7:0] target,
  output logic       fade_en,
  output logic [7:0] cur
);

  fade_state_t state, state_nxt;
  logic [7:0]  cur_nxt, cur_up, cur_dn;

  // min(v + FADE_STEP, lim) without 8-bit wrap
  function automatic logic [7:0] sat_up(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] sum;
    sum = {1'b0, v} + {1'b0, FADE_STEP};
    return (sum > {1'b0, lim}) ? lim : sum[7:0];
  endfunction

  // max(v - FADE_STEP, 0) without underflow
  function automatic logic [7:0] sat_dn(input logic [7:0] v);
    return (v > FADE_STEP) ? (v - FADE_STEP) : 8'h00;
  endfunction

  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      state <= FADE_OFF;
      cur   <= 8'h00;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cur_up    = sat_up(cur, target);
    cur_dn    = sat_dn(cur);
    if (frame_start) begin
      case (state)
        FADE_OFF: begin
          if (sl_en) begin
            state_nxt = FADE_IN;
            cur_nxt   = 8'h00;
          end
        end
        FADE_IN: begin
          cur_nxt = cur_up;
          if (!sl_en) begin
            state_nxt = FADE_OUT;
          end else if (cur_up == target) begin
            state_nxt = FADE_ON;
          end
        end
        FADE_ON: begin
          // Target changes while on take effect immediately
          cur_nxt = target;
          if (!sl_en) begin
            state_nxt = FADE_OUT;
          end
        end
        default: begin
          cur_nxt = cur_dn;
          if (sl_en) begin
            state_nxt = FADE_IN;
          end else if (cur_dn == 8'h00) begin
            state_nxt = FADE_OFF;
          end
        end
      endcase
    end
  end

  assign fade_en = (state != FADE_OFF);

endmodule

// File: rtl/scanline_ctrl.sv
// Per-frame sequencer and configuration shadow for the scanline datapath.
// Detects HSYNC/VSYNC leading edges, holds register-interface settings in a
// pending set until the next frame start, tracks the output-line phase against
// the source-line grid and produces the per-line relative position.
// Build option: define SCANLINE_CTRL_FADE_EN to fade strength in/out over
// several frames; otherwise enable and strength switch at the frame start.
// Ports:
//   VCLK_i, nVRST_i           : video clock, asynchronous active-low reset
//   HSYNC_i, VSYNC_i, DE_i    : video timing aligned with the datapath input
//   cfg_stb_i, cfg_*_i        : configuration strobe and values
//   cfg_pending_o             : a captured configuration awaits a frame start
//   sl_en_o .. sl_bloom_o     : registered controls for the scanline datapath
module scanline_ctrl
  import scanline_ctrl_pkg::*;
#(
  parameter logic [7:0] FADE_STEP       = 8'h10,
  parameter bit         SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       VCLK_i,
  input  logic       nVRST_i,
  input  logic       HSYNC_i,
  input  logic       VSYNC_i,
  input  logic       DE_i,
  input  logic       cfg_stb_i,
  input  logic       cfg_sl_en_i,
  input  logic       cfg_thickness_i,
  input  logic [1:0] cfg_profile_i,
  input  logic [7:0] cfg_strength_i,
  input  logic [4:0] cfg_bloom_i,
  input  logic [8:0] cfg_step_i,
  output logic       cfg_pending_o,
  output logic       sl_en_o,
  output logic       sl_thickness_o,
  output logic [1:0] sl_profile_o,
  output logic [7:0] sl_rel_pos_o,
  output logic [7:0] sl_strength_o,
  output logic [4:0] sl_bloom_o
);

  logic    hs_act_p0, vs_act_p0;
  logic    hs_act_p1, hs_act_p2, vs_act_p1, vs_act_p2, de_p1;
  logic    line_start, frame_start;
  sl_cfg_t cfg_in, pend, act, act_nxt;
  logic    pending;
  logic    de_seen;
  logic [7:0] phase;

  assign hs_act_p0 = SYNC_ACTIVE_LOW ? ~HSYNC_i : HSYNC_i;
  assign vs_act_p0 = SYNC_ACTIVE_LOW ? ~VSYNC_i : VSYNC_i;

  // ---- sync register stage ----
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      hs_act_p1 <= 1'b0;
      hs_act_p2 <= 1'b0;
      vs_act_p1 <= 1'b0;
      vs_act_p2 <= 1'b0;
      de_p1     <= 1'b0;
    end else begin
      hs_act_p1 <= hs_act_p0;
      hs_act_p2 <= hs_act_p1;
      vs_act_p1 <= vs_act_p0;
      vs_act_p2 <= vs_act_p1;
      de_p1     <= DE_i;
    end
  end

  assign line_start  = hs_act_p1 & ~hs_act_p2;
  assign frame_start = vs_act_p1 & ~vs_act_p2;

  always_comb begin
    cfg_in.en       = cfg_sl_en_i;
    cfg_in.thick    = cfg_thickness_i;
    cfg_in.profile  = cfg_profile_i;
    cfg_in.strength = cfg_strength_i;
    cfg_in.bloom    = cfg_bloom_i;
    cfg_in.step     = clamp_step(cfg_step_i);
  end

  // Settings that become active at this edge; the line math and fade logic
  // of a frame-start cycle must already see them.
  assign act_nxt = (frame_start && pending) ? pend : act;

  // ---- output register stage ----
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      pend    <= '0;
      pending <= 1'b0;
      act     <= '0;
    end else begin
      // A strobe coinciding with frame start stays pending for the next frame
      if (cfg_stb_i) begin
        pend    <= cfg_in;
        pending <= 1'b1;
      end else if (frame_start) begin
        pending <= 1'b0;
      end
      if (frame_start) begin
        act <= act_nxt;
      end
    end
  end

  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      de_seen      <= 1'b0;
      phase        <= 8'h00;
      sl_rel_pos_o <= 8'h00;
    end else begin
      if (line_start) begin
        de_seen <= 1'b0;
      end else if (de_p1) begin
        de_seen <= 1'b1;
      end
      if (frame_start) begin
        // Frame start wins over a coincident line start: phase restarts at 0
        phase <= 8'h00;
        if (line_start) begin
          sl_rel_pos_o <= act_nxt.step[8:1];
        end
      end else if (line_start) begin
        // Phase only advances across lines that carried active video
        if (de_seen) begin
          phase        <= phase + act.step[7:0];
          sl_rel_pos_o <= phase + act.step[7:0] + act.step[8:1];
        end else begin
          sl_rel_pos_o <= phase + act.step[8:1];
        end
      end
    end
  end

`ifdef SCANLINE_CTRL_FADE_EN
  scanline_fade_fsm #(
    .FADE_STEP (FADE_STEP)
  ) u_fade (
    .VCLK_i      (VCLK_i),
    .nVRST_i     (nVRST_i),
    .frame_start (frame_start),
    .sl_en       (act_nxt.en),
    .target      (act_nxt.strength),
    .fade_en     (sl_en_o),
    .cur         (sl_strength_o)
  );
`else
  logic unused_fade_step;
  assign unused_fade_step = ^FADE_STEP;

  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      sl_en_o       <= 1'b0;
      sl_strength_o <= 8'h00;
    end else if (frame_start) begin
      sl_en_o       <= act_nxt.en;
      sl_strength_o <= act_nxt.strength;
    end
  end
`endif

  assign cfg_pending_o  = pending;
  assign sl_thickness_o = act.thick;
  assign sl_profile_o   = act.profile;
  assign sl_bloom_o     = act.bloom;

endmodule
